// File: rtl/wb_result_logic_if.sv
// ----------------------------------------------------------------------------
// wb_result_logic_pkg / wb_result_logic_if
//
// Purpose:
//   Shared instruction enums and the bundled port interface of the
//   writeback result block (execute offer, data-memory return and
//   register-file write port).
//
// Interface signals (slave = the writeback block):
//   in_valid, in_ready          execute -> writeback handshake
//   pc, opcode_e, instr_type    offered instruction identity
//   rd_addr, alu_result         destination index / ALU result (load address)
//   dmem_rvalid, dmem_rdata     load data return (one-cycle pulse)
//   rf_we, rf_waddr, rf_wdata   register-file write port
//   load_misaligned             misaligned load pulse (WB_MISALIGN_CHECK_EN)
// ----------------------------------------------------------------------------
package wb_result_logic_pkg;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;

    typedef enum logic [2:0] {
        R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
    } rv32i_base_instr_type;

endpackage

interface wb_result_logic_if
    import wb_result_logic_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] pc;
    rv32i_base_instr       opcode_e;
    rv32i_base_instr_type  instr_type;
    logic [REG_AW-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  dmem_rvalid;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  rf_we;
    logic [REG_AW-1:0]     rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  load_misaligned;

    // Producer side: execute stage, data memory and register-file observer.
    modport master (
        output in_valid, pc, opcode_e, instr_type, rd_addr, alu_result,
               dmem_rvalid, dmem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, load_misaligned
    );

    // The writeback block itself.
    modport slave (
        input  in_valid, pc, opcode_e, instr_type, rd_addr, alu_result,
               dmem_rvalid, dmem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, load_misaligned
    );

endinterface

// File: rtl/wb_result_logic.sv
// ----------------------------------------------------------------------------
// wb_result_logic
//
// Purpose:
//   Result side of the execute stage. Accepts one instruction at a time,
//   chooses the register write value (ALU result, PC+4 for JAL/JALR, or
//   aligned and extended load data) and drives the register-file write port.
//   Loads stall the handshake until data memory returns the read word.
//
// Ports:
//   clk   in   core clock
//   rst   in   synchronous, active-high reset
//   bus   wb_result_logic_if.slave (handshake, dmem return, rf write port)
//
// Configuration:
//   WB_MISALIGN_CHECK_EN  when defined, a misaligned LH/LHU/LW suppresses the
//                         register write and pulses load_misaligned in its
//                         commit cycle; when undefined load_misaligned is 0
//                         and offsets below the lane size are ignored.
// ----------------------------------------------------------------------------
module wb_result_logic
    import wb_result_logic_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic             clk,
    input  logic             rst,
    wb_result_logic_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMMIT} state_t;

    state_t               state;

    // Fields of the accepted instruction needed once load data returns.
    rv32i_base_instr      ld_op;
    rv32i_base_instr_type ld_type;
    logic [REG_AW-1:0]    ld_rd;
    logic [1:0]           ld_off;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  nl_we;
    logic [DATA_WIDTH-1:0] nl_wdata;
    logic                  ld_we;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic                  ld_misal;

    function automatic logic is_load(input rv32i_base_instr op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    // Stores, branches and x0 destinations never write the register file.
    function automatic logic writes_rd(input rv32i_base_instr_type t,
                                       input logic [REG_AW-1:0]    rd);
        return !(t inside {S_TYPE, B_TYPE}) && (rd != '0);
    endfunction

    // Byte lane = off, halfword lane = off[1]; lower offset bits are ignored.
    function automatic logic [DATA_WIDTH-1:0] align_load(
        input rv32i_base_instr       op,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] raw
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = raw[{off, 3'b000} +: 8];
        h = raw[{off[1], 4'b0000} +: 16];
        case (op)
            LB:      r = {{(DATA_WIDTH-8){b[7]}}, b};
            LBU:     r = {{(DATA_WIDTH-8){1'b0}}, b};
            LH:      r = {{(DATA_WIDTH-16){h[15]}}, h};
            LHU:     r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign bus.in_ready = (state != WAIT_LOAD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign pc_plus4     = bus.pc + ADDR_WIDTH'(4);

    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        nl_we    = writes_rd(bus.instr_type, bus.rd_addr);
        nl_wdata = bus.alu_result;
        if (bus.opcode_e inside {JAL, JALR}) begin
            // Wraps modulo 2^ADDR_WIDTH, then zero-extends to the data width.
            nl_wdata = DATA_WIDTH'(pc_plus4);
        end

        ld_wdata = align_load(ld_op, ld_off, bus.dmem_rdata);
`ifdef WB_MISALIGN_CHECK_EN
        ld_misal = ((ld_op inside {LH, LHU}) && ld_off[0]) ||
                   ((ld_op == LW) && (ld_off != 2'b00));
`else
        ld_misal = 1'b0;
`endif
        ld_we = writes_rd(ld_type, ld_rd) && !ld_misal;
    end

`ifdef WB_MISALIGN_CHECK_EN
    logic misal_q;
    assign bus.load_misaligned = misal_q;
`else
    assign bus.load_misaligned = 1'b0;
`endif

    // The rf_* outputs are registered: they are loaded on the edge that
    // enters COMMIT, so rf_we is high exactly for the COMMIT cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ld_op        <= ADD;
            ld_type      <= R_TYPE;
            ld_rd        <= '0;
            ld_off       <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
`ifdef WB_MISALIGN_CHECK_EN
            misal_q      <= 1'b0;
`endif
        end else begin
            bus.rf_we <= 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
            misal_q   <= 1'b0;
`endif
            unique case (state)
                IDLE, COMMIT: begin
                    if (accept) begin
                        ld_op   <= bus.opcode_e;
                        ld_type <= bus.instr_type;
                        ld_rd   <= bus.rd_addr;
                        ld_off  <= bus.alu_result[1:0];
                        if (is_load(bus.opcode_e)) begin
                            // Any rvalid in this accept cycle is ignored.
                            state <= WAIT_LOAD;
                        end else begin
                            state <= COMMIT;
                            if (nl_we) begin
                                bus.rf_we    <= 1'b1;
                                bus.rf_waddr <= bus.rd_addr;
                                bus.rf_wdata <= nl_wdata;
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_LOAD: begin
                    if (bus.dmem_rvalid) begin
                        state <= COMMIT;
                        if (ld_we) begin
                            bus.rf_we    <= 1'b1;
                            bus.rf_waddr <= ld_rd;
                            bus.rf_wdata <= ld_wdata;
                        end
`ifdef WB_MISALIGN_CHECK_EN
                        misal_q <= ld_misal;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_result_logic.sv
// ----------------------------------------------------------------------------
// tb_wb_result_logic
//
// Purpose:
//   Directed bench for wb_result_logic. Each issued instruction pushes its
//   expected register write (cycle, index, data, or a misaligned pulse) into
//   a queue; a negedge monitor pops and compares whenever the block writes
//   or flags a misaligned load.
// ----------------------------------------------------------------------------
module tb_wb_result_logic;
    import wb_result_logic_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_result_logic_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_AW(5)) bus ();

    wb_result_logic #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic        misal;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write or misaligned pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst && (bus.rf_we || bus.load_misaligned)) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {31'd0, bus.rf_we}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_cycle", cyc, e.cyc);
                check("wb_misaligned", {31'd0, bus.load_misaligned}, {31'd0, e.misal});
                check("wb_we", {31'd0, bus.rf_we}, {31'd0, !e.misal});
                if (!e.misal) begin
                    check("wb_waddr", {27'd0, bus.rf_waddr}, {27'd0, e.addr});
                    check("wb_wdata", bus.rf_wdata, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input rv32i_base_instr op, input rv32i_base_instr_type ty,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu);
        bus.in_valid   = 1'b1;
        bus.opcode_e   = op;
        bus.instr_type = ty;
        bus.rd_addr    = rd;
        bus.pc         = pc;
        bus.alu_result = alu;
    endtask

    // Non-load: accepted on the next edge, write visible in the following cycle.
    task automatic issue(input rv32i_base_instr op, input rv32i_base_instr_type ty,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                         input bit writes, input logic [31:0] data);
        drive(op, ty, rd, pc, alu);
        check("in_ready_at_issue", {31'd0, bus.in_ready}, 32'd1);
        step();
        if (writes) sb.push_back('{cyc, 1'b0, rd, data});
    endtask

    // Load: rvalid arrives on the wait_cycles-th cycle after acceptance.
    task automatic load(input rv32i_base_instr op, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] rdata,
                        input int wait_cycles, input bit misal, input logic [31:0] data,
                        input bit early_rvalid);
        drive(op, I_TYPE, rd, 32'h0000_0040, addr);
        if (early_rvalid) begin
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = ~rdata;
        end
        check("in_ready_load_issue", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            check("in_ready_wait_load", {31'd0, bus.in_ready}, 32'd0);
            if (i == wait_cycles - 1) begin
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = rdata;
            end
            step();
        end
        bus.dmem_rvalid = 1'b0;
        sb.push_back('{cyc, misal, rd, data});
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.pc          = '0;
        bus.opcode_e    = ADD;
        bus.instr_type  = R_TYPE;
        bus.rd_addr     = '0;
        bus.alu_result  = '0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
        repeat (3) step();

        check("reset_rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("reset_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        check("reset_rf_wdata", bus.rf_wdata, 32'd0);
        check("reset_misaligned", {31'd0, bus.load_misaligned}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        step();

        // ALU result and PC+4 selection, including PC wrap.
        issue(ADD,  R_TYPE, 5'd5, 32'h0000_0000, 32'h0000_1234, 1, 32'h0000_1234);
        idle(1);
        issue(JAL,  J_TYPE, 5'd1, 32'h0000_0100, 32'hDEAD_0000, 1, 32'h0000_0104);
        issue(JALR, I_TYPE, 5'd2, 32'hFFFF_FFFC, 32'h0000_0800, 1, 32'h0000_0000);
        idle(1);

        // Byte loads with a 3-cycle stall; the LBU also has an early rvalid.
        load(LB,  5'd7, 32'h0000_1002, 32'h0080_0000, 3, 0, 32'hFFFF_FF80, 0);
        load(LBU, 5'd8, 32'h0000_1002, 32'h0080_0000, 3, 0, 32'h0000_0080, 1);
        idle(1);

        // Non-writing instructions flow without stalling; outputs hold.
        issue(SW,  S_TYPE, 5'd3, 32'h0, 32'h0000_0055, 0, 32'h0);
        issue(BEQ, B_TYPE, 5'd4, 32'h0, 32'h0000_0066, 0, 32'h0);
        issue(ADD, R_TYPE, 5'd0, 32'h0, 32'h0000_0099, 0, 32'h0);
        idle(1);
        check("hold_rf_waddr", {27'd0, bus.rf_waddr}, 32'd8);
        check("hold_rf_wdata", bus.rf_wdata, 32'h0000_0080);

        // Back-to-back writes every cycle.
        issue(ADD,  R_TYPE, 5'd5,  32'h0, 32'h0000_0001, 1, 32'h0000_0001);
        issue(ADDI, I_TYPE, 5'd6,  32'h0, 32'h0000_0002, 1, 32'h0000_0002);
        issue(LUI,  U_TYPE, 5'd12, 32'h0, 32'hABCD_0000, 1, 32'hABCD_0000);

        // Halfword/word loads; ADD accepted during the load's commit cycle.
        load(LHU, 5'd10, 32'h0000_0002, 32'h8001_0000, 1, 0, 32'h0000_8001, 0);
        issue(ADD, R_TYPE, 5'd13, 32'h0, 32'h0000_0077, 1, 32'h0000_0077);
        load(LW,  5'd11, 32'h0000_0004, 32'hDEAD_BEEF, 2, 0, 32'hDEAD_BEEF, 0);
        load(LH,  5'd14, 32'h0000_0000, 32'h1234_8765, 1, 0, 32'hFFFF_8765, 0);
        load(LB,  5'd15, 32'h0000_0003, 32'h7F00_0000, 1, 0, 32'h0000_007F, 0);
        idle(1);

        // Misaligned halfword and word loads.
`ifdef WB_MISALIGN_CHECK_EN
        load(LH, 5'd9,  32'h0000_2003, 32'hBEEF_0000, 1, 1, 32'h0, 0);
        load(LW, 5'd16, 32'h0000_0006, 32'h1122_3344, 1, 1, 32'h0, 0);
`else
        load(LH, 5'd9,  32'h0000_2003, 32'hBEEF_0000, 1, 0, 32'hFFFF_BEEF, 0);
        load(LW, 5'd16, 32'h0000_0006, 32'h1122_3344, 1, 0, 32'h1122_3344, 0);
`endif
        idle(1);

        // Stray rvalid while idle must not write.
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hCAFE_F00D;
        step();
        bus.dmem_rvalid = 1'b0;
        idle(1);

        // Reset while waiting for a load: no write, later rvalid ignored.
        drive(LW, I_TYPE, 5'd17, 32'h0, 32'h0000_0008);
        step();
        bus.in_valid = 1'b0;
        step();
        check("in_ready_before_rst", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h5555_AAAA;
        step();
        bus.dmem_rvalid = 1'b0;
        step();
        check("in_ready_after_stray", {31'd0, bus.in_ready}, 32'd1);
        check("rf_we_after_stray", {31'd0, bus.rf_we}, 32'd0);

        idle(2);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
